// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t  : FSM state encoding used by load_store_unit
//   F3_*         : RV32I load/store width codes carried on req_funct3
//   access_err() : misalignment / illegal-width check for one request
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        STORE_RD = 3'd2,
        STORE_WR = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // An access is rejected when the width code does not exist for its
    // direction (stores have no unsigned forms) or when it is not naturally
    // aligned to its own size.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic err;
        err = 1'b1;
        if (we) begin
            case (funct3)
                F3_B:    err = 1'b0;
                F3_H:    err = lane[0];
                F3_W:    err = (lane != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = lane[0];
                F3_W:        err = (lane != 2'b00);
                default:     err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path alignment for the load/store unit.
//   funct3     in  width code of the registered request
//   lane       in  byte lane within the word (addr[1:0])
//   rd_word    in  word read from data memory (load source)
//   merge_word in  word captured during the read half of a sub-word store
//   wdata      in  store data from the core
//   load_data  out selected byte/half/word, sign- or zero-extended
//   store_data out full word to write back to memory
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] merge_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {{(DATA_W-8){1'b0}}, ld_byte};
            F3_H:    load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            F3_HU:   load_data = {{(DATA_W-16){1'b0}}, ld_half};
            F3_W:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Sub-word stores are a read-modify-write: only the addressed lane of the
    // previously read word is replaced.
    always_comb begin
        store_data = wdata;
        case (funct3)
            F3_B:    store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H:    store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_data = wdata;
        endcase
        if (funct3 == F3_B) begin
            store_data = merge_word;
            store_data[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            store_data = merge_word;
            store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and performs it
// against a word-addressed data memory with a combinational read port.
// Core side:
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we, req_funct3   direction and RV32I width code
//   req_addr, req_wdata  byte address and store data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   load result / error flag, valid with rsp_valid
// Memory side:
//   mem_read, mem_write  access strobes (never both high)
//   mem_a                word index, mem_wd write data, mem_rd read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    lsu_state_t              state_q, state_d;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [DM_ADDRESS-1:0]   idx_q;
    logic [1:0]              lane_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    err_q;
    logic [DATA_W-1:0]       result_q;
    logic [DATA_W-1:0]       merge_q;

    logic                    accept;
    logic                    req_err;
    logic [DATA_W-1:0]       load_data;
    logic [DATA_W-1:0]       store_data;

    assign accept  = req_valid && (state_q == IDLE);
    assign req_err = access_err(req_we, req_funct3, req_addr[1:0]);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3     (funct3_q),
        .lane       (lane_q),
        .rd_word    (mem_rd),
        .merge_word (merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            merge_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                idx_q    <= req_addr[DM_ADDRESS+1:2];
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                // Cleared here so stores and errors respond with zero data.
                result_q <= '0;
                merge_q  <= '0;
            end
            if (state_q == LOAD) begin
                result_q <= load_data;
            end
            if (state_q == STORE_RD) begin
                merge_q <= mem_rd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = STORE_WR;
                    end else begin
                        state_d = STORE_RD;
                    end
                end
            end
            LOAD:     state_d = RESP;
            STORE_RD: state_d = STORE_WR;
            STORE_WR: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decode purely from the state register, so an asynchronous
    // reset drops every strobe at once and no write can leak out.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_read  = (state_q == LOAD) || (state_q == STORE_RD);
        mem_write = (state_q == STORE_WR);
        mem_a     = (mem_read || mem_write) ? idx_q : '0;
        mem_wd    = mem_write ? store_data : '0;
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rsp_valid ? result_q : '0;
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory
// model on the memory port.
module tb_load_store_unit;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_a;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;

    load_store_unit #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge. The bench can
    // also preset word 4 through the poke path.
    logic [31:0] mem [0:511];
    logic        poke;
    logic [31:0] poke_val;

    assign mem_rd = mem_read ? mem[mem_a] : 32'h0;

    always @(posedge clk) begin
        if (poke) mem[4] <= poke_val;
        else if (mem_write) mem[mem_a] <= mem_wd;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction.
    int          r_lat;
    int          r_nr;
    int          r_nw;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_wd;

    task automatic set_word4(input logic [31:0] v);
        @(negedge clk);
        poke = 1'b1;
        poke_val = v;
        @(posedge clk);
        #1 poke = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check("ready_before", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0; r_lat = 0; r_nr = 0; r_nw = 0; r_rdata = 'x; r_err = 1'bx; r_wd = 'x;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_read) r_nr++;
            if (mem_write) begin
                r_nw++;
                r_wd = mem_wd;
            end
            if (mem_read && mem_write) check("rd_wr_both", 32'd1, 32'd0);
            if (mem_read || mem_write) check("mem_a_busy", {23'b0, mem_a}, {23'b0, addr[10:2]});
            else check("mem_a_idle", {23'b0, mem_a}, 32'd0);
            if (rsp_valid) begin
                r_lat = i;
                r_rdata = rsp_rdata;
                r_err = rsp_err;
                got = 1;
                break;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    endtask

    task automatic expect_load(input string tag, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, f3, addr, 32'h0);
        check({tag, "_lat"},   r_lat, 32'd2);
        check({tag, "_rdata"}, r_rdata, exp);
        check({tag, "_err"},   {31'b0, r_err}, 32'd0);
        check({tag, "_nr"},    r_nr, 32'd1);
    endtask

    task automatic expect_error(input string tag, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr);
        do_req(we, f3, addr, 32'h5555_5555);
        check({tag, "_lat"},   r_lat, 32'd1);
        check({tag, "_err"},   {31'b0, r_err}, 32'd1);
        check({tag, "_rdata"}, r_rdata, 32'd0);
        check({tag, "_nrw"},   r_nr + r_nw, 32'd0);
    endtask

    initial begin
        int accepts, rsps, rsp_count;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        poke = 1'b1; poke_val = 32'h8899_AABB;
        repeat (2) @(posedge clk);
        #1 poke = 1'b0;

        // Reset state.
        check("rst_ready",  {31'b0, req_ready}, 32'd1);
        check("rst_rsp",    {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("rst_rdata",  rsp_rdata, 32'd0);
        check("rst_mem",    {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mem_a",  {23'b0, mem_a}, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads from word 4 = 0x8899AABB.
        expect_load("lb",  3'd0, 32'h0000_0011, 32'hFFFF_FFAA);
        expect_load("lbu", 3'd4, 32'h0000_0011, 32'h0000_00AA);
        expect_load("lh",  3'd1, 32'h0000_0012, 32'hFFFF_8899);
        expect_load("lhu", 3'd5, 32'h0000_0012, 32'h0000_8899);
        expect_load("lw",  3'd2, 32'h0000_0010, 32'h8899_AABB);
        expect_load("lb3", 3'd0, 32'hF000_0013, 32'hFFFF_FF88);

        // Sub-word stores: read then write.
        do_req(1'b1, 3'd0, 32'h0000_0013, 32'h0000_0012);
        check("sb_lat",   r_lat, 32'd3);
        check("sb_nr",    r_nr, 32'd1);
        check("sb_nw",    r_nw, 32'd1);
        check("sb_wd",    r_wd, 32'h1299_AABB);
        check("sb_rdata", r_rdata, 32'd0);
        check("sb_mem",   mem[4], 32'h1299_AABB);

        do_req(1'b1, 3'd1, 32'h0000_0010, 32'h0000_CAFE);
        check("sh_lat", r_lat, 32'd3);
        check("sh_wd",  r_wd, 32'h1299_CAFE);
        check("sh_mem", mem[4], 32'h1299_CAFE);

        do_req(1'b1, 3'd2, 32'h0000_0010, 32'h0102_0304);
        check("sw_lat", r_lat, 32'd2);
        check("sw_nr",  r_nr, 32'd0);
        check("sw_wd",  r_wd, 32'h0102_0304);
        check("sw_mem", mem[4], 32'h0102_0304);

        // Errors.
        expect_error("lw_mis", 1'b0, 3'd2, 32'h0000_0012);
        expect_error("sh_mis", 1'b1, 3'd1, 32'h0000_0011);
        expect_error("ld_f3",  1'b0, 3'd3, 32'h0000_0010);
        expect_error("st_f3",  1'b1, 3'd4, 32'h0000_0010);
        check("err_mem_kept", mem[4], 32'h0102_0304);

        // Reset while in STORE_WR.
        set_word4(32'h8899_AABB);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_wr_pre", {31'b0, mem_write}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_write", {31'b0, mem_write}, 32'd0);
        check("rst_wr_ready", {31'b0, req_ready}, 32'd1);
        check("rst_wr_wd",    mem_wd, 32'd0);
        @(posedge clk);
        #1 check("rst_wr_mem", mem[4], 32'h8899_AABB);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_count = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_count++;
        end
        check("rst_wr_norsp", rsp_count, 32'd0);
        check("rst_wr_mem2",  mem[4], 32'h8899_AABB);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0010;
        accepts = 0; rsps = 0;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) accepts++;
            if (rsp_valid) begin
                rsps++;
                check("b2b_rdata", rsp_rdata, 32'h8899_AABB);
                check("b2b_ready_in_resp", {31'b0, req_ready}, 32'd0);
            end
            if (i < 8) @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", accepts, 32'd3);
        check("b2b_rsps",    rsps, 32'd3);
        @(negedge clk);
        check("b2b_idle", {31'b0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DM_ADDRESS, default 9, giving the word-index width of the data memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data and address width.
REQ-003 The block SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have the core-side ports:
- req_valid  in  1  core request.
- req_ready  out  1  unit idle, request accepted.
- req_we  in  1  1 means store, 0 means load.
- req_funct3  in  3  RV32I width code: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
- req_addr  in  DATA_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result.
- rsp_err  out  1  misaligned or illegal access, valid with rsp_valid.
REQ-006 The block SHALL have the memory-side ports (initiator to the data memory):
- mem_read  out  1  MemRead.
- mem_write  out  1  MemWrite.
- mem_a  out  DM_ADDRESS  word index.
- mem_wd  out  DATA_W  write data.
- mem_rd  in  DATA_W  read data, combinational from mem_a while mem_read=1.

Function
REQ-007 The unit SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, registering we, funct3, addr and wdata.
- req_ready SHALL be 1 only in state IDLE.
REQ-008 The word index SHALL be req_addr[DM_ADDRESS+1:2], and the byte lane SHALL be req_addr[1:0].
- Higher address bits SHALL be ignored.
REQ-009 The FSM states SHALL be IDLE, LOAD, STORE_RD, STORE_WR, RESP, with these transitions:
- Aligned load: IDLE->LOAD->RESP->IDLE.
- SW: IDLE->STORE_WR->RESP->IDLE.
- SB/SH: IDLE->STORE_RD->STORE_WR->RESP->IDLE.
- Error: IDLE->RESP->IDLE.
REQ-010 An access SHALL be an error in these cases:
- LH/LHU/SH with addr[0]=1.
- LW/SW with addr[1:0]!=0.
- Load funct3 in {3,6,7}.
- Store funct3 >2.
An error access SHALL generate no mem_read or mem_write.
REQ-011 In LOAD, mem_read SHALL be 1, and mem_rd SHALL be extracted and extended into a result register at the closing edge. Extraction:
- LB/LBU: byte lane addr[1:0].
- LH/LHU: half lane addr[1].
- LB/LH: sign-extended; LBU/LHU: zero-extended.
REQ-012 In STORE_RD, mem_read SHALL be 1, and mem_rd SHALL be captured into a merge register.
REQ-013 In STORE_WR, mem_write SHALL be 1, and mem_wd SHALL be:
- SW: wdata.
- SB: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
- SH: the captured word with half lane addr[1] replaced by wdata[15:0].
REQ-014 mem_a SHALL equal the registered word index in LOAD, STORE_RD and STORE_WR, and SHALL be 0 otherwise.
- mem_wd SHALL be 0 outside STORE_WR.
- mem_read and mem_write SHALL never both be 1.
REQ-015 rsp_valid SHALL be 1 exactly in RESP, for one cycle; the response has no back-pressure.
- rsp_rdata SHALL be the load result for successful loads and 0 for stores and errors.
- rsp_err SHALL be 0 outside RESP.
REQ-016 Latency from the accepting edge to rsp_valid high SHALL be:
- Error: 1 cycle.
- Load and SW: 2 cycles.
- SB/SH: 3 cycles.
REQ-017 req_valid SHALL be ignored in every state other than IDLE.
- A new request can be accepted on the edge that leaves RESP only if the unit is already in IDLE; there is no overlap.

Reset
REQ-018 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE.
- req_ready=1.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
- mem_read=0, mem_write=0, mem_a=0, mem_wd=0.
- All internal registers to 0.
REQ-019 Reset asserted during any state, including STORE_WR, SHALL abandon the operation.
- No memory write SHALL occur on any edge while rst_n=0, and no response SHALL be issued.

Structure
REQ-020 A shared package lsu_pkg SHALL hold:
- The FSM state enum.
- The funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
REQ-021 The extraction/extension and merge logic SHALL live in one combinational sub-module lsu_align; load_store_unit holds the FSM and registers.

Verification
REQ-022 The bench SHALL cover these directed scenarios (memory word at index 4 = 0x8899AABB):
- LB addr 0x11 -> rsp_rdata 0xFFFFFFAA at 2 cycles; LBU 0x11 -> 0x000000AA.
- LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB; mem_a=4 throughout.
- SB addr 0x13 wdata 0x00000012 -> one mem_read cycle then one mem_write, mem_wd 0x1299AABB, rsp_valid at 3 cycles; SH 0x10 wdata 0xCAFE -> 0x1299CAFE.
- LW addr 0x12 and SH addr 0x11 -> rsp_err=1, rsp_rdata=0 at 1 cycle, mem_read and mem_write never asserted.
- rst_n pulsed low during STORE_WR of SW 0x10 wdata 0xDEADBEEF -> no write, word stays 0x8899AABB, no rsp_valid, req_ready=1.
- Back-to-back requests with req_valid held high -> each accepted only in IDLE, one rsp_valid per request.
